// File: rtl/moving_average_pkg.sv
// Moving-average shared definitions: window sizing,
// accumulator width and rounding-mode constants.
package moving_average_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  function automatic int ma_depth(int log2_depth);
    return 1 << log2_depth;
  endfunction

  function automatic int ma_acc_w(int data_w, int log2_depth);
    return data_w + log2_depth;
  endfunction

  function automatic int ma_round_bias(int round, int log2_depth);
    if (round == ROUND_HALF_UP && log2_depth > 0)
      return 1 << (log2_depth - 1);
    return 0;
  endfunction

endpackage

// File: rtl/ma_delay_line.sv
// Circular sample window; oldest_o is the sample that the
// next write overwrites, zero until the window has filled.
module ma_delay_line
  import moving_average_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  logic signed [DATA_W-1:0] wr_data_i,
  output logic signed [DATA_W-1:0] oldest_o
);

  localparam int DEPTH = ma_depth(LOG2_DEPTH);
  localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         ptr_q;
  logic [PTR_W-1:0]         ptr_d;

  assign ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0
                                              : ptr_q + 1'b1;
  assign oldest_o = mem_q[ptr_q];

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
    end else if (wr_en_i) begin
      mem_q[ptr_q] <= wr_data_i;
      ptr_q        <= ptr_d;
    end
  end

endmodule

// File: rtl/moving_average_param.sv
// Windowed running sum and mean over the last DEPTH
// accepted samples, result registered one cycle later.
module moving_average_param
  import moving_average_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 4,
  parameter int ROUND      = 0,
  localparam int ACC_W     = ma_acc_w(DATA_W, LOG2_DEPTH)
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_mean,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     window_full
);

  localparam int DEPTH = ma_depth(LOG2_DEPTH);
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic signed [ACC_W-1:0] BIAS =
    ACC_W'(ma_round_bias(ROUND, LOG2_DEPTH));

  logic                     accept;
  logic signed [DATA_W-1:0] oldest;
  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  old_ext;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [DATA_W-1:0] mean_q;
  logic signed [DATA_W-1:0] mean_d;
  logic                     valid_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;

  assign accept = in_valid & ~clear;

  ma_delay_line #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_line (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .clear_i         (clear),
    .wr_en_i         (accept),
    .wr_data_i       (in_data),
    .oldest_o        (oldest)
  );

  assign in_ext  = ACC_W'(in_data);
  assign old_ext = ACC_W'(oldest);
  assign sum_d   = sum_q + in_ext - old_ext;

  // Bias cannot overflow: max sum is below 2**(ACC_W-1) by DEPTH.
  assign rnd_sum = sum_d + BIAS;
  assign mean_d  = DATA_W'(rnd_sum >>> LOG2_DEPTH);

  assign cnt_d = (cnt_q == CNT_W'(DEPTH)) ? cnt_q
                                          : cnt_q + 1'b1;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      sum_q   <= '0;
      mean_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (clear) begin
      sum_q   <= '0;
      mean_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        sum_q  <= sum_d;
        mean_q <= mean_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_mean    = mean_q;
  assign out_sum     = sum_q;
  assign window_full = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_moving_average_param.sv
// Directed-vector bench for moving_average_param, with a
// truncating and a rounding instance driven in parallel.
module tb_moving_average_param;

  logic              clk;
  logic              rstn;
  logic              clear;
  logic              in_valid;
  logic signed [7:0] in_data;

  logic              out_valid, r_valid;
  logic signed [7:0] out_mean, r_mean;
  logic signed [11:0] out_sum, r_sum;
  logic              window_full, r_full;

  moving_average_param #(.DATA_W(8), .LOG2_DEPTH(4), .ROUND(0)) u_dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_mean        (out_mean),
    .out_sum         (out_sum),
    .window_full     (window_full)
  );

  moving_average_param #(.DATA_W(8), .LOG2_DEPTH(4), .ROUND(1)) u_rnd (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .out_valid       (r_valid),
    .out_mean        (r_mean),
    .out_sum         (r_sum),
    .window_full     (r_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic clr;
    logic vld;
    int   data;
    logic e_valid;
    int   e_sum;
    int   e_mean;
    int   e_mean_r;
    logic e_full;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_err;

  int   m_win[16];
  int   m_ptr;
  int   m_cnt;
  int   m_sum;

  function automatic vec_t mk(logic c, logic v, int d, logic ev,
                              int es, int em, int er, logic ef);
    vec_t t;
    t.clr = c; t.vld = v; t.data = d; t.e_valid = ev;
    t.e_sum = es; t.e_mean = em; t.e_mean_r = er; t.e_full = ef;
    return t;
  endfunction

  task automatic chk(string nm, int act, int exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic ev, int es, int em,
                           int er, logic ef);
    chk({tag, ".valid"},   int'(out_valid),   int'(ev));
    chk({tag, ".sum"},     int'(out_sum),     es);
    chk({tag, ".mean"},    int'(out_mean),    em);
    chk({tag, ".full"},    int'(window_full), int'(ef));
    chk({tag, ".r_valid"}, int'(r_valid),     int'(ev));
    chk({tag, ".r_sum"},   int'(r_sum),       es);
    chk({tag, ".r_mean"},  int'(r_mean),      er);
    chk({tag, ".r_full"},  int'(r_full),      int'(ef));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_win[i] = 0;
    m_ptr = 0; m_cnt = 0; m_sum = 0;
  endtask

  task automatic model_accept(int d);
    m_sum = m_sum + d - m_win[m_ptr];
    m_win[m_ptr] = d;
    m_ptr = (m_ptr + 1) % 16;
    if (m_cnt < 16) m_cnt++;
  endtask

  task automatic drive(logic c, logic v, int d);
    clear    = c;
    in_valid = v;
    in_data  = 8'(d);
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  // Drive one cycle, update the model, compare against it.
  task automatic mstep(string tag, logic c, logic v, int d);
    drive(c, v, d);
    if (c) model_clear();
    else if (v) model_accept(d);
    check_all(tag, v & ~c, m_sum, m_sum >>> 4, (m_sum + 8) >>> 4,
              m_cnt == 16);
  endtask

  int t_mean[10]   = '{3, 6, 9, 12, 15, 18, 21, 25, 28, 31};
  int t_mean_r[10] = '{3, 6, 9, 13, 16, 19, 22, 25, 28, 31};

  initial begin
    n_vec = 0; n_err = 0;
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    model_clear();

    for (int k = 1; k <= 16; k++)
      tbl.push_back(mk(0, 1, 16, 1, 16 * k, k, k, k == 16));
    tbl.push_back(mk(1, 1, 99, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8, 1, 8, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, -8, 1, -8, -1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(0, 1, 50, 1, 50 * k, t_mean[k-1],
                       t_mean_r[k-1], 0));
    tbl.push_back(mk(1, 1, 50, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32, 1, 32, 2, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    check_all("reset", 0, 0, 0, 0, 0);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].vld, tbl[i].data);
      check_all($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_sum,
                tbl[i].e_mean, tbl[i].e_mean_r, tbl[i].e_full);
    end
    model_clear();

    for (int i = 0; i < 32; i++) mstep("neg", 0, 1, -128);
    chk("neg_extreme.sum", int'(out_sum), -2048);
    chk("neg_extreme.mean", int'(out_mean), -128);
    for (int i = 0; i < 16; i++) mstep("pos", 0, 1, 127);
    chk("pos_extreme.sum", int'(out_sum), 2032);
    chk("pos_extreme.mean", int'(out_mean), 127);
    chk("pos_extreme.r_mean", int'(r_mean), 127);

    mstep("pre_rand", 1, 0, 0);
    begin
      int  n    = 0;
      int  cyc  = 0;
      bit  done = 0;
      while (n < 1000) begin
        logic v;
        int   d;
        v = ($urandom_range(3) == 0);
        d = int'($urandom_range(255)) - 128;
        if (n == 500 && !done) begin
          done = 1;
          rstn = 1'b0;
          #2;
          n_vec++;
          check_all("midreset", 0, 0, 0, 0, 0);
          model_clear();
          @(posedge clk);
          #1;
          rstn = 1'b1;
        end
        mstep("rand", 0, v, d);
        if (v) n++;
        cyc++;
        if (cyc > 20000) begin
          n_err++;
          $display("FAIL rand_budget: got %0d samples, want 1000", n);
          break;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
